// File: rtl/traffic_phase_scheduler.sv
// Two-way traffic controller with a pedestrian walk phase and emergency preempt.
// Green time stretches from GMIN to GMAX cycles, depending on demand from the opposing road or a waiting pedestrian.
module traffic_phase_scheduler #(
   parameter int CLOCK_FREQ_HZ = 50_000_000,
   parameter int GREEN_MIN_S   = 5,
   parameter int GREEN_MAX_S   = 30,
   parameter int YELLOW_TIME_S = 3,
   parameter int ALLRED_TIME_S = 2,
   parameter int WALK_TIME_S   = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ns_req,
   input  logic       ew_req,
   input  logic       ped_req,
   input  logic       emerg,
   output logic       ns_red,
   output logic       ns_yellow,
   output logic       ns_green,
   output logic       ew_red,
   output logic       ew_yellow,
   output logic       ew_green,
   output logic       walk,
   output logic       ped_ack,
   output logic [2:0] phase
);

   localparam int GMIN = GREEN_MIN_S * CLOCK_FREQ_HZ;
   localparam int GMAX = GREEN_MAX_S * CLOCK_FREQ_HZ;
   localparam int Y    = YELLOW_TIME_S * CLOCK_FREQ_HZ;
   localparam int AR   = ALLRED_TIME_S * CLOCK_FREQ_HZ;
   localparam int W    = WALK_TIME_S * CLOCK_FREQ_HZ;

   localparam int D_GY  = (GMAX > Y) ? GMAX : Y;
   localparam int D_GYA = (D_GY > AR) ? D_GY : AR;
   localparam int DMAX  = (D_GYA > W) ? D_GYA : W;
   localparam int CW    = (DMAX > 1) ? $clog2(DMAX) : 1;

   localparam logic [CW-1:0] GMIN_LAST = CW'(GMIN - 1);
   localparam logic [CW-1:0] GMAX_LAST = CW'(GMAX - 1);
   localparam logic [CW-1:0] Y_LAST    = CW'(Y - 1);
   localparam logic [CW-1:0] AR_LAST   = CW'(AR - 1);
   localparam logic [CW-1:0] W_LAST    = CW'(W - 1);

   localparam logic [2:0] NS_G   = 3'd0;
   localparam logic [2:0] NS_Y   = 3'd1;
   localparam logic [2:0] EW_G   = 3'd2;
   localparam logic [2:0] EW_Y   = 3'd3;
   localparam logic [2:0] ALLRED = 3'd4;
   localparam logic [2:0] WALK   = 3'd5;

   localparam logic DIR_NS = 1'b0;
   localparam logic DIR_EW = 1'b1;

   logic [2:0]    state;
   logic [2:0]    state_nxt;
   logic [CW-1:0] count;
   logic          ped_pend;
   logic          last_dir;
   logic          last_dir_nxt;

   always_comb begin
      state_nxt    = state;
      last_dir_nxt = last_dir;
      case (state)
         NS_G: begin
            if (emerg || (count >= GMIN_LAST && (ew_req || ped_pend)) || count == GMAX_LAST)
               state_nxt = NS_Y;
         end
         NS_Y: begin
            if (count == Y_LAST) begin
               state_nxt    = ALLRED;
               last_dir_nxt = DIR_NS;
            end
         end
         EW_G: begin
            if (emerg || (count >= GMIN_LAST && (ns_req || ped_pend)) || count == GMAX_LAST)
               state_nxt = EW_Y;
         end
         EW_Y: begin
            if (count == Y_LAST) begin
               state_nxt    = ALLRED;
               last_dir_nxt = DIR_EW;
            end
         end
         ALLRED: begin
            // Clearance only starts timing once the preempt has been released.
            if (!emerg && count == AR_LAST) begin
               if (ped_pend)
                  state_nxt = WALK;
               else
                  state_nxt = (last_dir == DIR_NS) ? EW_G : NS_G;
            end
         end
         WALK: begin
            if (emerg)
               state_nxt = ALLRED;
            else if (count == W_LAST)
               state_nxt = (last_dir == DIR_NS) ? EW_G : NS_G;
         end
         default: state_nxt = ALLRED;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= NS_G;
         count    <= '0;
         ped_pend <= 1'b0;
         last_dir <= DIR_EW;
      end else begin
         state    <= state_nxt;
         last_dir <= last_dir_nxt;
         if (state_nxt != state || (state == ALLRED && emerg))
            count <= '0;
         else
            count <= count + CW'(1);
         // A press during the walk being served is absorbed by that walk.
         if (state_nxt == WALK || state == WALK)
            ped_pend <= 1'b0;
         else if (ped_req)
            ped_pend <= 1'b1;
      end
   end

   always_comb begin
      ns_red    = 1'b1;
      ns_yellow = 1'b0;
      ns_green  = 1'b0;
      ew_red    = 1'b1;
      ew_yellow = 1'b0;
      ew_green  = 1'b0;
      walk      = 1'b0;
      case (state)
         NS_G: begin
            ns_red   = 1'b0;
            ns_green = 1'b1;
         end
         NS_Y: begin
            ns_red    = 1'b0;
            ns_yellow = 1'b1;
         end
         EW_G: begin
            ew_red   = 1'b0;
            ew_green = 1'b1;
         end
         EW_Y: begin
            ew_red    = 1'b0;
            ew_yellow = 1'b1;
         end
         WALK:    walk = 1'b1;
         default: walk = 1'b0;
      endcase
      ped_ack = (state == WALK) && (count == '0);
      phase   = state;
   end

endmodule

// File: doc/traffic_phase_scheduler.md
TRAFFIC_PHASE_SCHEDULER -- requirements
Module: traffic_phase_scheduler

Interface
REQ-001 Parameters SHALL be as follows:
- CLOCK_FREQ_HZ, default 50_000_000: clock cycles per second.
- GREEN_MIN_S, default 5: minimum green time, in seconds.
- GREEN_MAX_S, default 30: maximum green time, in seconds.
- YELLOW_TIME_S, default 3: yellow time, in seconds.
- ALLRED_TIME_S, default 2: all-red clearance time, in seconds.
- WALK_TIME_S, default 10: pedestrian walk time, in seconds.

REQ-002 Ports SHALL be as follows:
- clk, input, 1 bit: the single clock; all logic is rising-edge.
- rst, input, 1 bit: synchronous, active-low reset.
- ns_req, input, 1 bit: north-south vehicle detector, level.
- ew_req, input, 1 bit: east-west vehicle detector, level.
- ped_req, input, 1 bit: pedestrian button, pulse or level.
- emerg, input, 1 bit: emergency preempt, level.
- ns_red, ns_yellow, ns_green, output, 1 bit each: north-south lamps.
- ew_red, ew_yellow, ew_green, output, 1 bit each: east-west lamps.
- walk, output, 1 bit: pedestrian walk lamp.
- ped_ack, output, 1 bit: one-cycle pulse when a pedestrian request is served.
- phase, output, 3 bits: current state code.

Function
REQ-003 The state register SHALL hold one of these states, with the given phase codes: NS_G=0, NS_Y=1, EW_G=2, EW_Y=3, ALLRED=4, WALK=5. Codes 6 and 7 SHALL recover to ALLRED on the next cycle.

REQ-004 Durations SHALL be in cycles, each equal to the named *_S parameter times CLOCK_FREQ_HZ:
- GMIN (green minimum), GMAX (green maximum), Y (yellow), AR (all-red), W (walk).
- The dwell counter width SHALL be $clog2 of the largest duration.
- The dwell counter SHALL clear to 0 on every state entry and increment by 1 each cycle in the state.

REQ-005 All outputs SHALL be decoded from registered state only, with no combinational path from any input to any output.

REQ-006 Lamp mapping SHALL be:
- Each direction's lamp group is one-hot.
- ns_green/ns_yellow are active only in NS_G/NS_Y; ew_green/ew_yellow only in EW_G/EW_Y.
- The direction not named by the state shows red.
- ALLRED and WALK show both directions red.
- walk=1 only in WALK.

REQ-007 ped_req SHALL set a ped_pend flag on any cycle it is high. Entering WALK SHALL clear ped_pend, and clear SHALL win over a same-cycle set.

REQ-008 NS_G SHALL go to NS_Y on the first cycle that any of these holds, checked in this priority order:
- emerg=1;
- count>=GMIN-1 and (ew_req or ped_pend);
- count==GMAX-1.
EW_G SHALL behave symmetrically, using ns_req.

REQ-009 NS_Y and EW_Y SHALL run exactly Y cycles, even if emerg is high, then go to ALLRED. On exit they SHALL record last_dir (NS or EW).

REQ-010 ALLRED SHALL behave as follows:
- While emerg=1, hold ALLRED with count held at 0.
- Otherwise, after AR cycles, go to WALK if ped_pend=1.
- Otherwise go to the green opposite last_dir.

REQ-011 WALK SHALL run W cycles, then go to the green opposite last_dir. If emerg rises during WALK, it SHALL go to ALLRED on the next cycle; ped_pend stays cleared.

REQ-012 ped_ack SHALL be 1 for exactly the first cycle of WALK.

REQ-013 Green dwell SHALL be bounded to GMIN..GMAX cycles when emerg=0. The block SHALL never go directly from green to the opposite green, from yellow to green, or from WALK to yellow.

REQ-014 Request inputs SHALL be sampled with no latency beyond one clock: an exit condition true at edge k produces the new state after edge k.

Reset
REQ-015 When rst=0 at a clock edge, the block SHALL load the following on that edge:
- state=NS_G, count=0, ped_pend=0, last_dir=EW.
- Resulting outputs: ns_green=1, ew_red=1, all other lamps 0, walk=0, ped_ack=0, phase=0.

REQ-016 Reset asserted mid-operation, in any state, SHALL override all transitions on that edge.

Verification
The bench SHALL use CLOCK_FREQ_HZ=10, GREEN_MIN_S=1, GREEN_MAX_S=3, YELLOW_TIME_S=1, ALLRED_TIME_S=1, WALK_TIME_S=2. This gives GMIN=10, GMAX=30, Y=10, AR=10, W=20 cycles.

REQ-017 Idle cycle: rst low for 5 cycles, then all requests 0 -> the bench SHALL see:
- NS_G for 30 cycles, NS_Y 10, ALLRED 10, EW_G 30, EW_Y 10, ALLRED 10, then NS_G again.
- At every cycle, no lamp group non-one-hot and never green in both directions.

REQ-018 Demand: ew_req=1 held from reset release -> ns_yellow SHALL rise on the 11th cycle after release. EW_G SHALL then last 30 cycles if ns_req=0.

REQ-019 Pedestrian: single-cycle ped_req pulse at EW_G count 3 -> the bench SHALL see:
- EW_Y at count 9, then ALLRED for 10 cycles.
- WALK for 20 cycles with ped_ack on its first cycle only, then NS_G.

REQ-020 Preempt: emerg=1 at NS_G count 5, held 25 cycles -> the bench SHALL see:
- NS_Y on the next cycle, lasting 10 cycles.
- ALLRED held while emerg=1, then 10 more cycles after emerg falls, then EW_G.

REQ-021 Reset mid-WALK: rst=0 for one edge at WALK count 7 -> on the next cycle the bench SHALL see phase=0, walk=0, ns_green=1, ped_ack=0. With no new ped_req, no WALK SHALL follow the next ALLRED.

REQ-022 Simultaneous events: ped_req=1 on the exact cycle WALK is entered -> ped_pend SHALL be 0 afterward, and only one WALK SHALL occur.
